// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART RX definitions: FSM state encoding, parity modes and
//          the legal oversampling ratios.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam logic EVEN_PARITY = 1'b0;
  localparam logic ODD_PARITY  = 1'b1;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

endpackage

`default_nettype wire

// File: rtl/rx_edge_bit_counter.sv
// ============================================================================
// Module : rx_edge_bit_counter
// Brief  : Oversampling edge counter with bit-end wrap, plus the data bit
//          counter, both with enable and clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rx_edge_bit_counter #(
  parameter int PRESC_WIDTH = 6,
  parameter int BIT_CNT_W   = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   i_edge_en,
  input  logic                   i_edge_clr,
  input  logic                   i_bit_inc,
  input  logic                   i_bit_clr,
  input  logic [PRESC_WIDTH-1:0] i_presc,
  output logic [PRESC_WIDTH-1:0] o_edge_cnt,
  output logic [BIT_CNT_W-1:0]   o_bit_cnt,
  output logic                   o_bit_end
);

  logic [PRESC_WIDTH-1:0] w_last_edge;

  assign w_last_edge = i_presc - {{(PRESC_WIDTH-1){1'b0}}, 1'b1};
  assign o_bit_end   = (o_edge_cnt == w_last_edge);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      o_edge_cnt <= '0;
      o_bit_cnt  <= '0;
    end else begin
      if (i_edge_clr)
        o_edge_cnt <= '0;
      else if (i_edge_en)
        o_edge_cnt <= o_bit_end ? '0 : o_edge_cnt + {{(PRESC_WIDTH-1){1'b0}}, 1'b1};

      if (i_bit_clr)
        o_bit_cnt <= '0;
      else if (i_bit_inc)
        o_bit_cnt <= o_bit_cnt + {{(BIT_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_frame_ctrl.sv
// ============================================================================
// Module : uart_rx_frame_ctrl
// Brief  : UART RX sequencing FSM: drives the datapath enables, collects the
//          checker errors and emits one data_valid / frame_error per frame.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6,
  parameter int BIT_CNT_W   = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RX_IN,
  input  logic                   PAR_EN,
  input  logic [PRESC_WIDTH-1:0] PRESCALE,
  input  logic                   sampling_done,
  input  logic                   strt_glitch,
  input  logic                   par_err,
  input  logic                   stp_err,
  output logic [PRESC_WIDTH-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]   bit_cnt,
  output logic                   dat_samp_en,
  output logic                   deser_en,
  output logic                   strt_chk_en,
  output logic                   par_chk_en,
  output logic                   stp_chk_en,
  output logic                   data_valid,
  output logic                   frame_error,
  output logic                   busy
);

  rx_state_t              r_state;
  rx_state_t              w_next;
  logic [PRESC_WIDTH-1:0] r_presc;
  logic                   r_par_en;
  logic                   r_samp_d;
  logic                   r_par_flag;
  logic                   r_stp_flag;

  logic w_bit_end;
  logic w_last_bit;
  logic w_enter_start;
  logic w_frame_end;
  logic w_stp_bad;
  logic w_bad;

  rx_edge_bit_counter #(
    .PRESC_WIDTH (PRESC_WIDTH),
    .BIT_CNT_W   (BIT_CNT_W)
  ) u_cnt (
    .CLK        (CLK),
    .RST        (RST),
    .i_edge_en  (r_state != ST_IDLE),
    .i_edge_clr (r_state == ST_IDLE),
    .i_bit_inc  ((r_state == ST_DATA) && w_bit_end && !w_last_bit),
    .i_bit_clr  ((r_state != ST_DATA) || (w_bit_end && w_last_bit)),
    .i_presc    (r_presc),
    .o_edge_cnt (edge_cnt),
    .o_bit_cnt  (bit_cnt),
    .o_bit_end  (w_bit_end)
  );

  assign w_last_bit    = (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1));
  assign w_enter_start = (w_next == ST_START) && (r_state != ST_START);
  assign w_frame_end   = (r_state == ST_STOP) && w_bit_end;
  // A stop result landing on the final cycle is folded in directly.
  assign w_stp_bad     = r_stp_flag || (r_samp_d && stp_err);
  assign w_bad         = r_par_flag || w_stp_bad;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (!RX_IN) w_next = ST_START;
      ST_START:  if (w_bit_end) w_next = strt_glitch ? ST_IDLE : ST_DATA;
      ST_DATA:   if (w_bit_end && w_last_bit) w_next = r_par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_bit_end) w_next = ST_STOP;
      ST_STOP:   if (w_bit_end) w_next = RX_IN ? ST_IDLE : ST_START;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= ST_IDLE;
      r_presc     <= '0;
      r_par_en    <= 1'b0;
      r_samp_d    <= 1'b0;
      r_par_flag  <= 1'b0;
      r_stp_flag  <= 1'b0;
      dat_samp_en <= 1'b0;
      deser_en    <= 1'b0;
      strt_chk_en <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_samp_d <= sampling_done && (r_state != ST_IDLE);

      // Config is frozen per frame; back-to-back frames relatch on START entry.
      if (w_enter_start) begin
        r_presc    <= PRESCALE;
        r_par_en   <= PAR_EN;
        r_par_flag <= 1'b0;
        r_stp_flag <= 1'b0;
      end else begin
        if ((r_state == ST_PARITY) && r_samp_d)
          r_par_flag <= r_par_flag | par_err;
        if ((r_state == ST_STOP) && r_samp_d)
          r_stp_flag <= r_stp_flag | stp_err;
      end

      deser_en    <= (r_state == ST_DATA) && sampling_done;
      dat_samp_en <= (w_next != ST_IDLE);
      busy        <= (w_next != ST_IDLE);
      strt_chk_en <= (w_next == ST_START);
      par_chk_en  <= (w_next == ST_PARITY);
      stp_chk_en  <= (w_next == ST_STOP);
      data_valid  <= w_frame_end && !w_bad;
      frame_error <= w_frame_end && w_bad;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame_ctrl.sv
// ============================================================================
// Module : tb_uart_rx_frame_ctrl
// Brief  : Directed self-checking bench for uart_rx_frame_ctrl with a small
//          behavioural sampler/checker model around the FSM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_frame_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic [5:0] PRESCALE = 6'd8;
  logic       sampling_done = 1'b0;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;

  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic       data_valid, frame_error, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         presc_m = 8;
  logic       exp_par = 1'b0;
  logic       samp_bit = 1'b1;
  int         n_deser, n_dv, n_fe, dv_cyc, dv_prev, fe_cyc;
  logic       par_seen;
  logic [7:0] rx_byte;

  uart_rx_frame_ctrl #(
    .DATA_WIDTH  (8),
    .PRESC_WIDTH (6),
    .BIT_CNT_W   (4)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .RX_IN         (RX_IN),
    .PAR_EN        (PAR_EN),
    .PRESCALE      (PRESCALE),
    .sampling_done (sampling_done),
    .strt_glitch   (strt_glitch),
    .par_err       (par_err),
    .stp_err       (stp_err),
    .edge_cnt      (edge_cnt),
    .bit_cnt       (bit_cnt),
    .dat_samp_en   (dat_samp_en),
    .deser_en      (deser_en),
    .strt_chk_en   (strt_chk_en),
    .par_chk_en    (par_chk_en),
    .stp_chk_en    (stp_chk_en),
    .data_valid    (data_valid),
    .frame_error   (frame_error),
    .busy          (busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Sampler and checkers: mid-bit sample, results held until the next sample.
  always @(negedge CLK) begin
    if (!dat_samp_en) begin
      sampling_done = 1'b0;
      strt_glitch   = 1'b0;
      par_err       = 1'b0;
      stp_err       = 1'b0;
    end else if (edge_cnt == 6'(presc_m / 2)) begin
      sampling_done = 1'b1;
      samp_bit      = RX_IN;
      if (strt_chk_en) strt_glitch = RX_IN;
      if (par_chk_en)  par_err     = RX_IN ^ exp_par;
      if (stp_chk_en)  stp_err     = ~RX_IN;
    end else begin
      sampling_done = 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (deser_en) begin
      n_deser = n_deser + 1;
      rx_byte = {samp_bit, rx_byte[7:1]};
    end
    if (par_chk_en) par_seen = 1'b1;
    if (data_valid) begin
      n_dv    = n_dv + 1;
      dv_prev = dv_cyc;
      dv_cyc  = cyc;
    end
    if (frame_error) begin
      n_fe   = n_fe + 1;
      fe_cyc = cyc;
    end
  end

  task automatic clear_mon();
    n_deser  = 0;
    n_dv     = 0;
    n_fe     = 0;
    dv_cyc   = 0;
    dv_prev  = 0;
    fe_cyc   = 0;
    par_seen = 1'b0;
    rx_byte  = 8'h00;
  endtask

  // Called at a negedge; returns at the negedge after the last frame cycle.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit,
                            input logic sbit, input int p, output int start_cyc);
    exp_par   = ^d;
    RX_IN     = 1'b0;
    start_cyc = cyc + 1;
    repeat (p) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      repeat (p) @(negedge CLK);
    end
    if (pe) begin
      RX_IN = pbit;
      repeat (p) @(negedge CLK);
    end
    RX_IN = sbit;
    repeat (p) @(negedge CLK);
    RX_IN = 1'b1;
  endtask

  function automatic logic [17:0] all_outs();
    return {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
            stp_chk_en, data_valid, frame_error, busy};
  endfunction

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (all_outs() !== 18'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", all_outs());
    end
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy got %b exp 0", busy);
    end
    checks++;
    if (edge_cnt !== 6'd0) begin
      errors++;
      $display("FAIL reset_idle_edge got %0d exp 0", edge_cnt);
    end
  endtask

  task automatic test_parity_ok();
    int s;
    PRESCALE = 6'd8; PAR_EN = 1'b1; presc_m = 8;
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 8, s);
    repeat (4) @(negedge CLK);
    checks++;
    if (n_deser !== 8) begin errors++; $display("FAIL t1_deser_count got %0d exp 8", n_deser); end
    checks++;
    if (rx_byte !== 8'hA5) begin errors++; $display("FAIL t1_deser_data got %h exp a5", rx_byte); end
    checks++;
    if (n_dv !== 1) begin errors++; $display("FAIL t1_dv_count got %0d exp 1", n_dv); end
    checks++;
    if (dv_cyc - s !== 88) begin errors++; $display("FAIL t1_dv_latency got %0d exp 88", dv_cyc - s); end
    checks++;
    if (n_fe !== 0) begin errors++; $display("FAIL t1_fe_count got %0d exp 0", n_fe); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL t1_idle_after got %b exp 0", busy); end
  endtask

  task automatic test_parity_err();
    int s;
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 8, s);
    repeat (4) @(negedge CLK);
    checks++;
    if (n_fe !== 1) begin errors++; $display("FAIL t2_fe_count got %0d exp 1", n_fe); end
    checks++;
    if (fe_cyc - s !== 88) begin errors++; $display("FAIL t2_fe_latency got %0d exp 88", fe_cyc - s); end
    checks++;
    if (n_dv !== 0) begin errors++; $display("FAIL t2_dv_count got %0d exp 0", n_dv); end
  endtask

  task automatic test_start_glitch();
    clear_mon();
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (6) @(negedge CLK);
    checks++;
    if ({busy, strt_chk_en} !== 2'b11) begin
      errors++;
      $display("FAIL t3_in_start got %b exp 11", {busy, strt_chk_en});
    end
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL t3_back_idle got %b exp 0", busy); end
    repeat (4) @(negedge CLK);
    checks++;
    if (n_deser !== 0) begin errors++; $display("FAIL t3_deser_count got %0d exp 0", n_deser); end
    checks++;
    if (n_dv + n_fe !== 0) begin errors++; $display("FAIL t3_pulses got %0d exp 0", n_dv + n_fe); end
  endtask

  task automatic test_no_parity();
    int s;
    PAR_EN = 1'b0;
    clear_mon();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 8, s);
    repeat (4) @(negedge CLK);
    checks++;
    if (par_seen !== 1'b0) begin errors++; $display("FAIL t4_par_chk_en got %b exp 0", par_seen); end
    checks++;
    if (n_fe !== 1) begin errors++; $display("FAIL t4_fe_count got %0d exp 1", n_fe); end
    checks++;
    if (fe_cyc - s !== 80) begin errors++; $display("FAIL t4_fe_latency got %0d exp 80", fe_cyc - s); end
    checks++;
    if (n_dv !== 0) begin errors++; $display("FAIL t4_dv_count got %0d exp 0", n_dv); end
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    PRESCALE = 6'd16; PAR_EN = 1'b1; presc_m = 16;
    clear_mon();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16, s1);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b1, 16, s2);
    repeat (4) @(negedge CLK);
    checks++;
    if (n_dv !== 2) begin errors++; $display("FAIL t5_dv_count got %0d exp 2", n_dv); end
    checks++;
    if (dv_cyc - dv_prev !== 176) begin errors++; $display("FAIL t5_dv_gap got %0d exp 176", dv_cyc - dv_prev); end
    checks++;
    if (dv_cyc - s1 !== 352) begin errors++; $display("FAIL t5_dv2_latency got %0d exp 352", dv_cyc - s1); end
    checks++;
    if (n_deser !== 16) begin errors++; $display("FAIL t5_deser_count got %0d exp 16", n_deser); end
    checks++;
    if (rx_byte !== 8'hC3) begin errors++; $display("FAIL t5_deser_data got %h exp c3", rx_byte); end
    checks++;
    if (n_fe !== 0) begin errors++; $display("FAIL t5_fe_count got %0d exp 0", n_fe); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int s;
    d = 8'hA5;
    PRESCALE = 6'd8; PAR_EN = 1'b1; presc_m = 8;
    clear_mon();
    exp_par = ^d;
    RX_IN = 1'b0;
    repeat (8) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      RX_IN = d[i];
      if (i == 1) PRESCALE = 6'd32;
      repeat (8) @(negedge CLK);
    end
    RX_IN = d[4];
    repeat (3) @(negedge CLK);
    checks++;
    if ({bit_cnt, edge_cnt} !== {4'd4, 6'd2}) begin
      errors++;
      $display("FAIL t6_cfg_held got bit %0d edge %0d exp bit 4 edge 2", bit_cnt, edge_cnt);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if (all_outs() !== 18'h0) begin
      errors++;
      $display("FAIL t6_async_reset got %h exp 0", all_outs());
    end
    RX_IN = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    checks++;
    if (n_dv + n_fe !== 0) begin errors++; $display("FAIL t6_stale_pulse got %0d exp 0", n_dv + n_fe); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL t6_idle_after_rst got %b exp 0", busy); end
    presc_m = 32;
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 32, s);
    repeat (4) @(negedge CLK);
    checks++;
    if (n_dv !== 1) begin errors++; $display("FAIL t6_dv_count got %0d exp 1", n_dv); end
    checks++;
    if (dv_cyc - s !== 352) begin errors++; $display("FAIL t6_dv_latency got %0d exp 352", dv_cyc - s); end
    checks++;
    if (rx_byte !== 8'hA5) begin errors++; $display("FAIL t6_deser_data got %h exp a5", rx_byte); end
  endtask

  initial begin
    clear_mon();
    @(negedge CLK);
    test_reset();
    test_parity_ok();
    test_parity_err();
    test_start_glitch();
    test_no_parity();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
